// File: rtl/video_src_sched.sv
// ----------------------------------------------------------------------------
// video_src_sched
//    Frame-synchronous source scheduler for the HDMI output path. Qualifies the
//    camera stream (line count per frame and VS activity), then hands the
//    pixel mux over to the camera at an output frame boundary. A camera loss
//    while the camera is on air drops back to the test pattern at once.
//
// Ports
//    i_sys_clk     pixel clock, all inputs synchronous to it
//    i_sys_rst_n   asynchronous active-low reset
//    i_force_pat   level, 1 = hold the test pattern
//    i_cam_vs      camera vertical sync (active high)
//    i_cam_de      camera data enable (active high)
//    i_out_vs      output timing vertical sync, rising edge = switch point
//    o_src_sel     registered mux select, 0 = pattern, 1 = camera
//    o_cam_locked  registered, 1 while armed or on camera
//    o_loss_pulse  registered one-cycle pulse on a loss while on camera
//    o_good_cnt    consecutive valid frames seen while qualifying (sat. 15)
//    o_err_cnt     loss events (sat. 255)
// ----------------------------------------------------------------------------
module video_src_sched #(
   parameter int V_ACTIVE     = 720,
   parameter int GOOD_FRAMES  = 4,
   parameter int LOSS_TIMEOUT = 2_000_000
) (
   input  logic       i_sys_clk,
   input  logic       i_sys_rst_n,
   input  logic       i_force_pat,
   input  logic       i_cam_vs,
   input  logic       i_cam_de,
   input  logic       i_out_vs,
   output logic       o_src_sel,
   output logic       o_cam_locked,
   output logic       o_loss_pulse,
   output logic [3:0] o_good_cnt,
   output logic [7:0] o_err_cnt
);

   localparam int              TW        = $clog2(LOSS_TIMEOUT + 1);
   localparam logic [TW-1:0]   TMO_MAX   = TW'(LOSS_TIMEOUT);
   localparam logic [11:0]     LINES_OK  = 12'(V_ACTIVE);
   localparam logic [3:0]      GOOD_MAX  = 4'(GOOD_FRAMES);

   typedef enum logic [1:0] {
      ST_PAT  = 2'd0,
      ST_QUAL = 2'd1,
      ST_ARM  = 2'd2,
      ST_CAM  = 2'd3
   } state_t;

   state_t        r_state;
   state_t        w_state_nxt;
   logic          r_cam_vs_d;
   logic          r_cam_de_d;
   logic          r_out_vs_d;
   logic [11:0]   r_line_cnt;
   logic [TW-1:0] r_timer;
   logic          r_src_sel;
   logic          r_cam_locked;
   logic          r_loss_pulse;
   logic [3:0]    r_good_cnt;
   logic [7:0]    r_err_cnt;

   logic          w_vs_rise;
   logic          w_de_rise;
   logic          w_ovs_rise;
   logic          w_frame_ok;
   logic          w_frame_bad;
   logic          w_timeout;
   logic [3:0]    w_good_inc;
   logic [7:0]    w_err_inc;
   logic [3:0]    w_good_nxt;
   logic [7:0]    w_err_nxt;
   logic          w_loss_nxt;

   assign w_vs_rise  = i_cam_vs & ~r_cam_vs_d;
   assign w_de_rise  = i_cam_de & ~r_cam_de_d;
   assign w_ovs_rise = i_out_vs & ~r_out_vs_d;
   // The line count still holds the frame that just ended when its VS rises.
   assign w_frame_ok  = w_vs_rise & (r_line_cnt == LINES_OK);
   assign w_frame_bad = w_vs_rise & (r_line_cnt != LINES_OK);
   // A VS rise in the same cycle as the saturated timer is not a loss.
   assign w_timeout   = (r_timer == TMO_MAX) & ~w_vs_rise;
   assign w_good_inc  = (r_good_cnt == 4'd15)  ? 4'd15  : r_good_cnt + 4'd1;
   assign w_err_inc   = (r_err_cnt  == 8'hFF)  ? 8'hFF  : r_err_cnt + 8'd1;

   assign o_src_sel    = r_src_sel;
   assign o_cam_locked = r_cam_locked;
   assign o_loss_pulse = r_loss_pulse;
   assign o_good_cnt   = r_good_cnt;
   assign o_err_cnt    = r_err_cnt;

   // Input delay registers for rising-edge detection.
   always_ff @(posedge i_sys_clk or negedge i_sys_rst_n) begin
      if (!i_sys_rst_n) begin
         r_cam_vs_d <= 1'b0;
         r_cam_de_d <= 1'b0;
         r_out_vs_d <= 1'b0;
      end else begin
         r_cam_vs_d <= i_cam_vs;
         r_cam_de_d <= i_cam_de;
         r_out_vs_d <= i_out_vs;
      end
   end

   // Saturating line counter; a DE rise coinciding with VS is line 1 of the new frame.
   always_ff @(posedge i_sys_clk or negedge i_sys_rst_n) begin
      if (!i_sys_rst_n) begin
         r_line_cnt <= 12'd0;
      end else if (w_vs_rise) begin
         r_line_cnt <= w_de_rise ? 12'd1 : 12'd0;
      end else if (w_de_rise && (r_line_cnt != 12'hFFF)) begin
         r_line_cnt <= r_line_cnt + 12'd1;
      end else begin
         r_line_cnt <= r_line_cnt;
      end
   end

   // Loss timer: cycles since the last camera VS rise, saturating.
   always_ff @(posedge i_sys_clk or negedge i_sys_rst_n) begin
      if (!i_sys_rst_n) begin
         r_timer <= '0;
      end else if (w_vs_rise) begin
         r_timer <= '0;
      end else if (r_timer != TMO_MAX) begin
         r_timer <= r_timer + TW'(1);
      end else begin
         r_timer <= r_timer;
      end
   end

   // Next-state and next-output decode for the source state machine.
   always_comb begin
      w_state_nxt = r_state;
      w_good_nxt  = r_good_cnt;
      w_err_nxt   = r_err_cnt;
      w_loss_nxt  = 1'b0;
      case (r_state)
         ST_PAT: begin
            w_good_nxt = 4'd0;
            if (w_vs_rise && !i_force_pat) begin
               w_state_nxt = ST_QUAL;
            end else begin
               w_state_nxt = ST_PAT;
            end
         end
         ST_QUAL: begin
            if (i_force_pat || w_timeout) begin
               w_state_nxt = ST_PAT;
               w_good_nxt  = 4'd0;
            end else if (w_frame_ok) begin
               w_good_nxt = w_good_inc;
               if (w_good_inc == GOOD_MAX) begin
                  w_state_nxt = ST_ARM;
               end else begin
                  w_state_nxt = ST_QUAL;
               end
            end else if (w_frame_bad) begin
               w_state_nxt = ST_QUAL;
               w_good_nxt  = 4'd0;
            end else begin
               w_state_nxt = ST_QUAL;
            end
         end
         ST_ARM: begin
            if (i_force_pat || w_timeout || w_frame_bad) begin
               w_state_nxt = ST_PAT;
               w_good_nxt  = 4'd0;
            end else if (w_ovs_rise) begin
               w_state_nxt = ST_CAM;
            end else begin
               w_state_nxt = ST_ARM;
            end
         end
         ST_CAM: begin
            // Loss takes priority over a forced switch at the same boundary.
            if (w_timeout || w_frame_bad) begin
               w_state_nxt = ST_PAT;
               w_good_nxt  = 4'd0;
               w_loss_nxt  = 1'b1;
               w_err_nxt   = w_err_inc;
            end else if (i_force_pat && w_ovs_rise) begin
               w_state_nxt = ST_PAT;
               w_good_nxt  = 4'd0;
            end else begin
               w_state_nxt = ST_CAM;
            end
         end
         default: begin
            w_state_nxt = ST_PAT;
            w_good_nxt  = 4'd0;
         end
      endcase
   end

   // State register and registered outputs, all following the next state.
   always_ff @(posedge i_sys_clk or negedge i_sys_rst_n) begin
      if (!i_sys_rst_n) begin
         r_state      <= ST_PAT;
         r_src_sel    <= 1'b0;
         r_cam_locked <= 1'b0;
         r_loss_pulse <= 1'b0;
         r_good_cnt   <= 4'd0;
         r_err_cnt    <= 8'd0;
      end else begin
         r_state      <= w_state_nxt;
         r_src_sel    <= (w_state_nxt == ST_CAM);
         r_cam_locked <= (w_state_nxt == ST_ARM) || (w_state_nxt == ST_CAM);
         r_loss_pulse <= w_loss_nxt;
         r_good_cnt   <= w_good_nxt;
         r_err_cnt    <= w_err_nxt;
      end
   end

endmodule

// File: tb/tb_video_src_sched.sv
// ----------------------------------------------------------------------------
// tb_video_src_sched
//    Directed scenario tasks plus a randomized run against a frame-level
//    reference model of the scheduler.
// ----------------------------------------------------------------------------
module tb_video_src_sched;

   localparam int V_ACTIVE     = 4;
   localparam int GOOD_FRAMES  = 3;
   localparam int LOSS_TIMEOUT = 1000;

   logic       clk       = 1'b0;
   logic       rst_n     = 1'b0;
   logic       force_pat = 1'b0;
   logic       cam_vs    = 1'b0;
   logic       cam_de    = 1'b0;
   logic       out_vs    = 1'b0;
   logic       src_sel;
   logic       cam_locked;
   logic       loss_pulse;
   logic [3:0] good_cnt;
   logic [7:0] err_cnt;

   int total     = 0;
   int bad       = 0;
   int cyc       = 0;
   int last_rise = 0;

   always #5 clk = ~clk;

   video_src_sched #(
      .V_ACTIVE    (V_ACTIVE),
      .GOOD_FRAMES (GOOD_FRAMES),
      .LOSS_TIMEOUT(LOSS_TIMEOUT)
   ) dut (
      .i_sys_clk   (clk),
      .i_sys_rst_n (rst_n),
      .i_force_pat (force_pat),
      .i_cam_vs    (cam_vs),
      .i_cam_de    (cam_de),
      .i_out_vs    (out_vs),
      .o_src_sel   (src_sel),
      .o_cam_locked(cam_locked),
      .o_loss_pulse(loss_pulse),
      .o_good_cnt  (good_cnt),
      .o_err_cnt   (err_cnt)
   );

   // ---------------- reference model (frame-level view) ----------------
   localparam int M_PATTERN = 0;
   localparam int M_QUALIFY = 1;
   localparam int M_ARMED   = 2;
   localparam int M_CAMERA  = 3;

   int m_mode, m_good, m_err, m_lines, m_since;
   bit m_pv, m_pd, m_po;
   bit e_src, e_lock, e_loss;

   function automatic void model_reset();
      m_mode = M_PATTERN; m_good = 0; m_err = 0; m_lines = 0; m_since = 0;
      m_pv = 0; m_pd = 0; m_po = 0;
      e_src = 0; e_lock = 0; e_loss = 0;
   endfunction

   function automatic void model_clock(bit f, bit vs, bit de, bit ov);
      bit vs_up, de_up, ov_up, lost_sync, ended_ok, ended_bad;
      int nxt;
      vs_up     = vs && !m_pv;
      de_up     = de && !m_pd;
      ov_up     = ov && !m_po;
      lost_sync = !vs_up && (m_since >= LOSS_TIMEOUT);
      ended_ok  = vs_up && (m_lines == V_ACTIVE);
      ended_bad = vs_up && (m_lines != V_ACTIVE);
      nxt    = m_mode;
      e_loss = 0;
      case (m_mode)
         M_PATTERN: if (vs_up && !f) nxt = M_QUALIFY;
         M_QUALIFY: begin
            if (f || lost_sync) nxt = M_PATTERN;
            else if (ended_ok) begin
               m_good = (m_good < 15) ? m_good + 1 : 15;
               if (m_good == GOOD_FRAMES) nxt = M_ARMED;
            end else if (ended_bad) m_good = 0;
         end
         M_ARMED: begin
            if (f || lost_sync || ended_bad) nxt = M_PATTERN;
            else if (ov_up) nxt = M_CAMERA;
         end
         M_CAMERA: begin
            if (lost_sync || ended_bad) begin
               nxt = M_PATTERN;
               e_loss = 1;
               if (m_err < 255) m_err = m_err + 1;
            end else if (f && ov_up) nxt = M_PATTERN;
         end
         default: nxt = M_PATTERN;
      endcase
      if (nxt == M_PATTERN) m_good = 0;
      m_mode = nxt;
      e_src  = (nxt == M_CAMERA);
      e_lock = (nxt == M_ARMED) || (nxt == M_CAMERA);
      if (vs_up) m_lines = de_up ? 1 : 0;
      else if (de_up) m_lines = (m_lines < 4095) ? m_lines + 1 : 4095;
      m_since = vs_up ? 0 : m_since + 1;
      m_pv = vs; m_pd = de; m_po = ov;
   endfunction

   // ---------------- stimulus helpers ----------------
   task automatic step();
      @(posedge clk);
      if (!rst_n) model_reset();
      else model_clock(force_pat, cam_vs, cam_de, out_vs);
      cyc = cyc + 1;
      #1;
   endtask

   task automatic send_vs();
      cam_vs = 1'b1;
      step();
      last_rise = cyc;
      step();
      cam_vs = 1'b0;
      step();
   endtask

   task automatic send_lines(input int n);
      for (int i = 0; i < n; i++) begin
         cam_de = 1'b1;
         repeat (3) step();
         cam_de = 1'b0;
         repeat (2) step();
      end
   endtask

   task automatic pulse_out();
      out_vs = 1'b1;
      repeat (2) step();
      out_vs = 1'b0;
      step();
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      model_reset();
      cam_vs = 1'b0; cam_de = 1'b0; out_vs = 1'b0; force_pat = 1'b0;
      repeat (2) step();
      rst_n = 1'b1;
      step();
   endtask

   task automatic qualify();
      send_vs();
      repeat (GOOD_FRAMES) begin
         send_lines(V_ACTIVE);
         send_vs();
      end
      pulse_out();
   endtask

   task automatic bring_up();
      do_reset();
      qualify();
   endtask

   // ---------------- scenarios ----------------
   task automatic test_reset();
      rst_n = 1'b0;
      repeat (2) step();
      total++; if (src_sel !== 1'b0)    begin bad++; $display("FAIL reset_src: got %0b want 0", src_sel); end
      total++; if (cam_locked !== 1'b0) begin bad++; $display("FAIL reset_lock: got %0b want 0", cam_locked); end
      total++; if (loss_pulse !== 1'b0) begin bad++; $display("FAIL reset_loss: got %0b want 0", loss_pulse); end
      total++; if (good_cnt !== 4'd0)   begin bad++; $display("FAIL reset_good: got %0d want 0", good_cnt); end
      total++; if (err_cnt !== 8'd0)    begin bad++; $display("FAIL reset_err: got %0d want 0", err_cnt); end
      rst_n = 1'b1;
      step();
   endtask

   task automatic test_bad_frame();
      do_reset();
      send_vs();
      repeat (2) begin
         send_lines(4);
         send_vs();
      end
      total++; if (good_cnt !== 4'd2) begin bad++; $display("FAIL badf_pre_good: got %0d want 2", good_cnt); end
      send_lines(3);
      send_vs();
      total++; if (good_cnt !== 4'd0)   begin bad++; $display("FAIL badf_good: got %0d want 0", good_cnt); end
      total++; if (src_sel !== 1'b0)    begin bad++; $display("FAIL badf_src: got %0b want 0", src_sel); end
      total++; if (cam_locked !== 1'b0) begin bad++; $display("FAIL badf_lock: got %0b want 0", cam_locked); end
   endtask

   task automatic test_qualify();
      do_reset();
      send_vs();
      repeat (3) begin
         send_lines(4);
         send_vs();
      end
      total++; if (good_cnt !== 4'd3)   begin bad++; $display("FAIL qual_good: got %0d want 3", good_cnt); end
      total++; if (cam_locked !== 1'b1) begin bad++; $display("FAIL qual_lock: got %0b want 1", cam_locked); end
      total++; if (src_sel !== 1'b0)    begin bad++; $display("FAIL qual_src_armed: got %0b want 0", src_sel); end
      out_vs = 1'b1;
      #2;
      total++; if (src_sel !== 1'b0) begin bad++; $display("FAIL qual_src_early: got %0b want 0", src_sel); end
      step();
      total++; if (src_sel !== 1'b1) begin bad++; $display("FAIL qual_src_switch: got %0b want 1", src_sel); end
      step();
      out_vs = 1'b0;
      step();
      total++; if (src_sel !== 1'b1) begin bad++; $display("FAIL qual_src_hold: got %0b want 1", src_sel); end
   endtask

   task automatic test_loss();
      bring_up();
      send_lines(4);
      send_vs();
      total++; if (src_sel !== 1'b1) begin bad++; $display("FAIL loss_pre_src: got %0b want 1", src_sel); end
      while (cyc < last_rise + LOSS_TIMEOUT) step();
      total++; if (src_sel !== 1'b1)    begin bad++; $display("FAIL loss_src_early: got %0b want 1", src_sel); end
      total++; if (loss_pulse !== 1'b0) begin bad++; $display("FAIL loss_pulse_early: got %0b want 0", loss_pulse); end
      step();
      total++; if (src_sel !== 1'b0)    begin bad++; $display("FAIL loss_src: got %0b want 0", src_sel); end
      total++; if (loss_pulse !== 1'b1) begin bad++; $display("FAIL loss_pulse: got %0b want 1", loss_pulse); end
      total++; if (err_cnt !== 8'd1)    begin bad++; $display("FAIL loss_err: got %0d want 1", err_cnt); end
      total++; if (cam_locked !== 1'b0) begin bad++; $display("FAIL loss_lock: got %0b want 0", cam_locked); end
      total++; if (good_cnt !== 4'd0)   begin bad++; $display("FAIL loss_good: got %0d want 0", good_cnt); end
      step();
      total++; if (loss_pulse !== 1'b0) begin bad++; $display("FAIL loss_pulse_len: got %0b want 0", loss_pulse); end
      total++; if (src_sel !== 1'b0)    begin bad++; $display("FAIL loss_src_stay: got %0b want 0", src_sel); end
   endtask

   task automatic test_force();
      bring_up();
      force_pat = 1'b1;
      repeat (6) step();
      total++; if (src_sel !== 1'b1)    begin bad++; $display("FAIL force_src_hold: got %0b want 1", src_sel); end
      total++; if (cam_locked !== 1'b1) begin bad++; $display("FAIL force_lock_hold: got %0b want 1", cam_locked); end
      out_vs = 1'b1;
      step();
      total++; if (src_sel !== 1'b0)    begin bad++; $display("FAIL force_src: got %0b want 0", src_sel); end
      total++; if (loss_pulse !== 1'b0) begin bad++; $display("FAIL force_loss: got %0b want 0", loss_pulse); end
      total++; if (err_cnt !== 8'd0)    begin bad++; $display("FAIL force_err: got %0d want 0", err_cnt); end
      total++; if (cam_locked !== 1'b0) begin bad++; $display("FAIL force_lock: got %0b want 0", cam_locked); end
      step();
      out_vs = 1'b0;
      step();
      force_pat = 1'b0;
      step();
   endtask

   task automatic test_same_cycle();
      bring_up();
      send_lines(4);
      send_vs();
      send_lines(4);
      while (cyc < last_rise + LOSS_TIMEOUT) step();
      cam_vs = 1'b1;
      cam_de = 1'b1;
      step();
      total++; if (loss_pulse !== 1'b0) begin bad++; $display("FAIL same_loss: got %0b want 0", loss_pulse); end
      total++; if (src_sel !== 1'b1)    begin bad++; $display("FAIL same_src: got %0b want 1", src_sel); end
      step();
      cam_vs = 1'b0;
      step();
      cam_de = 1'b0;
      repeat (2) step();
      send_lines(3);
      total++; if (src_sel !== 1'b1) begin bad++; $display("FAIL same_timer_restart: got %0b want 1", src_sel); end
      send_vs();
      total++; if (src_sel !== 1'b1) begin bad++; $display("FAIL same_frame_valid: got %0b want 1", src_sel); end
      total++; if (err_cnt !== 8'd0) begin bad++; $display("FAIL same_err: got %0d want 0", err_cnt); end
   endtask

   task automatic test_saturate();
      bring_up();
      for (int i = 1; i <= 256; i++) begin
         cam_vs = 1'b1;
         step();
         total++; if (loss_pulse !== 1'b1) begin bad++; $display("FAIL sat_pulse[%0d]: got %0b want 1", i, loss_pulse); end
         total++; if (err_cnt !== 8'((i > 255) ? 255 : i)) begin
            bad++; $display("FAIL sat_err[%0d]: got %0d want %0d", i, err_cnt, (i > 255) ? 255 : i);
         end
         step();
         cam_vs = 1'b0;
         step();
         if (i < 256) qualify();
      end
   endtask

   task automatic test_reset_mid();
      qualify();
      total++; if (src_sel !== 1'b1)  begin bad++; $display("FAIL rmid_pre_src: got %0b want 1", src_sel); end
      total++; if (err_cnt !== 8'd255) begin bad++; $display("FAIL rmid_pre_err: got %0d want 255", err_cnt); end
      send_lines(2);
      cam_de = 1'b1;
      step();
      rst_n = 1'b0;
      model_reset();
      cam_de = 1'b0;
      #2;
      total++; if (src_sel !== 1'b0)    begin bad++; $display("FAIL rmid_src: got %0b want 0", src_sel); end
      total++; if (cam_locked !== 1'b0) begin bad++; $display("FAIL rmid_lock: got %0b want 0", cam_locked); end
      total++; if (loss_pulse !== 1'b0) begin bad++; $display("FAIL rmid_loss: got %0b want 0", loss_pulse); end
      total++; if (good_cnt !== 4'd0)   begin bad++; $display("FAIL rmid_good: got %0d want 0", good_cnt); end
      total++; if (err_cnt !== 8'd0)    begin bad++; $display("FAIL rmid_err: got %0d want 0", err_cnt); end
      repeat (2) step();
      rst_n = 1'b1;
      step();
      send_vs();
      repeat (2) begin
         send_lines(4);
         send_vs();
      end
      total++; if (good_cnt !== 4'd2)   begin bad++; $display("FAIL rmid_good2: got %0d want 2", good_cnt); end
      total++; if (cam_locked !== 1'b0) begin bad++; $display("FAIL rmid_lock2: got %0b want 0", cam_locked); end
      send_lines(4);
      send_vs();
      total++; if (good_cnt !== 4'd3)   begin bad++; $display("FAIL rmid_good3: got %0d want 3", good_cnt); end
      total++; if (cam_locked !== 1'b1) begin bad++; $display("FAIL rmid_lock3: got %0b want 1", cam_locked); end
   endtask

   task automatic test_random();
      bit [1:0] q[$];
      int       ov_left;
      int       nl;
      do_reset();
      ov_left = 0;
      for (int fr = 0; fr < 160; fr++) begin
         q.delete();
         q.push_back(2'b10); q.push_back(2'b10); q.push_back(2'b00);
         case ($urandom_range(0, 5))
            0:       nl = 3;
            1:       nl = 5;
            default: nl = 4;
         endcase
         for (int l = 0; l < nl; l++) begin
            repeat (3) q.push_back(2'b01);
            repeat (2) q.push_back(2'b00);
         end
         repeat ($urandom_range(0, 3)) q.push_back(2'b00);
         if ($urandom_range(0, 19) == 0) repeat (LOSS_TIMEOUT + 10) q.push_back(2'b00);
         force_pat = ($urandom_range(0, 9) == 0);
         foreach (q[k]) begin
            cam_vs = q[k][1];
            cam_de = q[k][0];
            if (ov_left > 0) begin
               out_vs = 1'b1;
               ov_left--;
            end else if ($urandom_range(0, 29) == 0) begin
               out_vs = 1'b1;
               ov_left = 1;
            end else begin
               out_vs = 1'b0;
            end
            step();
            total++; if (src_sel !== e_src) begin bad++; $display("FAIL rnd_src@%0d: got %0b want %0b", cyc, src_sel, e_src); end
            total++; if (cam_locked !== e_lock) begin bad++; $display("FAIL rnd_lock@%0d: got %0b want %0b", cyc, cam_locked, e_lock); end
            total++; if (loss_pulse !== e_loss) begin bad++; $display("FAIL rnd_loss@%0d: got %0b want %0b", cyc, loss_pulse, e_loss); end
            total++; if (good_cnt !== 4'(m_good)) begin bad++; $display("FAIL rnd_good@%0d: got %0d want %0d", cyc, good_cnt, m_good); end
            total++; if (err_cnt !== 8'(m_err)) begin bad++; $display("FAIL rnd_err@%0d: got %0d want %0d", cyc, err_cnt, m_err); end
         end
      end
      force_pat = 1'b0;
      out_vs    = 1'b0;
   endtask

   initial begin
      model_reset();
      test_reset();
      test_bad_frame();
      test_qualify();
      test_loss();
      test_force();
      test_same_cycle();
      test_saturate();
      test_reset_mid();
      test_random();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/video_src_sched.md
# video_src_sched

Frame-synchronous source scheduler for the HDMI output path. It qualifies the incoming camera video stream, chooses between the local test-pattern generator and the camera stream, and drives the select of the pixel multiplexer that feeds the HDMI encoder. Source changes happen only at an output frame boundary, except on camera loss, which falls back to the pattern at once. It runs in the pixel clock domain (x1 clock), next to the timing generator.

## Interface
- V_ACTIVE, default 720: active lines per valid camera frame.
- GOOD_FRAMES, default 4: consecutive valid camera frames needed before switching to the camera.
- LOSS_TIMEOUT, default 2_000_000: cycles without a camera VS rising edge that count as loss.

- sys_clk  in  1  pixel clock (x1); every input is synchronous to it.
- sys_rst_n  in  1  asynchronous active-low reset.
- force_pat  in  1  level; 1 = hold the test pattern.
- cam_vs  in  1  camera vertical sync, active high.
- cam_de  in  1  camera data enable, active high.
- out_vs  in  1  output timing vertical sync, active high; its rising edge is the switch point.
- src_sel  out  1  registered; 0 = pattern, 1 = camera.
- cam_locked  out  1  registered; 1 while in state ARM or CAM.
- loss_pulse  out  1  registered one-cycle pulse on camera loss while in CAM.
- good_cnt  out  4  consecutive valid frames seen in QUAL; saturates at 15.
- err_cnt  out  8  loss events; saturates at 255.

## Operation
- Edge detection:
  - cam_vs, cam_de and out_vs each have a one-register delay.
  - The rise signal for each is `x & ~x_d`, combinational in the cycle where the input is first sampled high.
- Line counter:
  - 12 bits, saturating at 4095.
  - Increments on each cam_de rise.
  - Cleared on each cam_vs rise.
  - If a cam_de rise and a cam_vs rise occur in the same cycle, the line counter loads 1 (the line belongs to the new frame).
- Frame check: at each cam_vs rise, the frame just ended is valid iff the line count equals V_ACTIVE.
- Timer:
  - Width $clog2(LOSS_TIMEOUT+1).
  - Cleared on a cam_vs rise; otherwise increments and saturates at LOSS_TIMEOUT.
  - timeout = (timer == LOSS_TIMEOUT) with no cam_vs rise in that cycle. A cam_vs rise in the same cycle wins over timeout.
- State machine:
  - PAT: src_sel=0, good_cnt=0. Goes to QUAL on a cam_vs rise while force_pat=0. That rise only starts the counters; the frame it ends is not evaluated.
  - QUAL: src_sel=0.
    - Valid frame: good_cnt+1. Invalid frame: good_cnt is cleared and the state stays QUAL.
    - When a valid frame brings good_cnt to GOOD_FRAMES, go to ARM.
    - timeout or force_pat=1: go to PAT. No loss_pulse, err_cnt unchanged.
  - ARM: src_sel=0.
    - out_vs rise: go to CAM.
    - timeout, invalid frame or force_pat=1: go to PAT. No loss_pulse.
  - CAM: src_sel=1.
    - timeout or invalid frame: go to PAT, src_sel=0, loss_pulse=1 for one cycle, err_cnt+1.
    - force_pat=1: stay in CAM until the next out_vs rise, then go to PAT. This is not a loss.
    - If loss and the out_vs rise occur in the same cycle as force_pat, the loss handling applies.
- Reset mid-operation:
  - All registers return asynchronously to their reset values.
  - Counters are cleared and the state is PAT.
  - The next qualification restarts from zero.

## Timing
- Reset values: src_sel=0, cam_locked=0, loss_pulse=0, good_cnt=0, err_cnt=0. Internal: state PAT, timer 0, line counter 0, edge registers 0.
- Switch latency:
  - out_vs first sampled high in cycle n while in ARM: src_sel=1 from cycle n+1.
  - Same in CAM with force_pat=1: src_sel=0 from cycle n+1.
- Loss latency: a loss condition in cycle n gives src_sel=0 and loss_pulse=1 in cycle n+1, and loss_pulse=0 in cycle n+2.
- cam_locked and good_cnt update in the same cycle as the state change (one cycle after the triggering edge is sampled).
- The timeout fires LOSS_TIMEOUT cycles after the last cam_vs rise.

## Test plan
Bench parameters: V_ACTIVE=4, GOOD_FRAMES=3, LOSS_TIMEOUT=1000.

- Reset, then feed 4 camera frames of 4 lines each, then one out_vs pulse:
  - good_cnt reaches 3.
  - cam_locked=1.
  - src_sel=1 exactly one cycle after the out_vs edge, not before.
- In QUAL with good_cnt=2, feed a frame of 3 lines: good_cnt returns to 0 and src_sel stays 0.
- In CAM, stop cam_vs:
  - 1000 cycles after the last rise, src_sel drops to 0.
  - loss_pulse is high for exactly 1 cycle.
  - err_cnt goes 0→1.
  - The state goes to PAT.
- In CAM, assert force_pat:
  - src_sel stays 1 until the next out_vs rise, then becomes 0.
  - loss_pulse=0 and err_cnt is unchanged.
- In CAM, drive a cam_vs rise on the same cycle as timer==1000: no loss occurs and the timer restarts. Drive cam_de and cam_vs rises in the same cycle: the next frame counts 4 lines as valid.
- Force 256 losses: err_cnt saturates at 255. Pulse sys_rst_n low mid-frame in CAM: all outputs are 0 immediately, and requalification needs 3 fresh valid frames.
